// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA text buffer write controller.
// VGA_BUF_SCROLL_EN enables the SCROLL command.
package vga_pkg;

  localparam int VGA_ADDR_W = 12;
  localparam int VGA_H_W    = 7;
  localparam int VGA_V_W    = 5;
  localparam logic [31:0] VGA_FILL_DEFAULT = 32'hFFF00020;

  typedef enum logic [1:0] {
    VGA_NOP,
    VGA_CLR_ALL,
    VGA_CLR_LINE,
    VGA_SCROLL
  } vga_cmd_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  // Ops that actually start the engine; without scroll support op 3 acts as NOP.
  function automatic logic vga_op_supported(input vga_cmd_t op);
`ifdef VGA_BUF_SCROLL_EN
    return (op != VGA_NOP);
`else
    return (op == VGA_CLR_ALL) || (op == VGA_CLR_LINE);
`endif
  endfunction

  function automatic logic [31:0] vga_fill_sel(input logic [31:0] fill,
                                               input logic [31:0] dflt);
    return (fill == 32'd0) ? dflt : fill;
  endfunction

endpackage

// File: rtl/vga_fill_engine.sv
// Address generator for hardware fills: linear sweep of the whole buffer or
// a column sweep of one line. The pointer holds whenever stall is high.
module vga_fill_engine
  import vga_pkg::*;
#(
  parameter int H_CHARS = 80,
  parameter int V_LINES = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  active,
  input  logic                  stall,
  input  logic                  linear,
  input  logic [VGA_V_W-1:0]    line,
  output logic [VGA_ADDR_W-1:0] addr,
  output logic                  last
);

  localparam int DEPTH = (1 << VGA_H_W) * V_LINES;
  localparam logic [VGA_ADDR_W-1:0] LIN_LAST = VGA_ADDR_W'(DEPTH - 1);
  localparam logic [VGA_H_W-1:0]    COL_LAST = VGA_H_W'(H_CHARS - 1);

  logic [VGA_ADDR_W-1:0] lin_ptr_reg;
  logic [VGA_H_W-1:0]    col_ptr_reg;
  logic                  step;

  assign step = active & ~stall;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lin_ptr_reg <= '0;
      col_ptr_reg <= '0;
    end else if (start) begin
      lin_ptr_reg <= '0;
      col_ptr_reg <= '0;
    end else if (step) begin
      if (linear) lin_ptr_reg <= lin_ptr_reg + 1'b1;
      else        col_ptr_reg <= col_ptr_reg + 1'b1;
    end
  end

  assign addr = linear ? lin_ptr_reg : {col_ptr_reg, line};
  assign last = step & (linear ? (lin_ptr_reg == LIN_LAST) : (col_ptr_reg == COL_LAST));

endmodule

// File: rtl/vga_buf_ctrl.sv
// Write-port owner for the VGA text buffer: CPU/fill-engine mux, command FSM
// and line_offset rotation. SCROLL is available when VGA_BUF_SCROLL_EN is defined.
module vga_buf_ctrl
  import vga_pkg::*;
#(
  parameter int          H_CHARS   = 80,
  parameter int          V_LINES   = 32,
  parameter logic [31:0] FILL_WORD = VGA_FILL_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_we,
  input  logic [VGA_ADDR_W-1:0] cpu_addr,
  input  logic [31:0]           cpu_wdata,
  input  logic                  line_we,
  input  logic [VGA_V_W-1:0]    line_wdata,
  input  logic                  cmd_valid,
  input  logic [1:0]            cmd_op,
  input  logic [VGA_V_W-1:0]    cmd_line,
  input  logic [31:0]           cmd_fill,
  output logic                  cmd_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_we,
  output logic [VGA_ADDR_W-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [VGA_V_W-1:0]    line_offset
);

  state_t                state_reg, state_next;
  vga_cmd_t              op_reg;
  logic [VGA_V_W-1:0]    line_reg;
  logic [31:0]           fill_reg;
  logic [VGA_V_W-1:0]    line_offset_reg;
  vga_cmd_t              cmd_op_t;
  logic                  accept;
  logic                  eng_active;
  logic                  eng_last;
  logic [VGA_ADDR_W-1:0] eng_addr;

  assign cmd_op_t   = vga_cmd_t'(cmd_op);
  assign accept     = (state_reg == S_IDLE) & cmd_valid & vga_op_supported(cmd_op_t);
  assign eng_active = (state_reg == S_RUN);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (accept) state_next = S_RUN;
      S_RUN:   if (eng_last) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      op_reg    <= VGA_NOP;
      line_reg  <= '0;
      fill_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_reg   <= cmd_op_t;
        // SCROLL clears whichever row is currently displayed at the top
        line_reg <= (cmd_op_t == VGA_SCROLL) ? line_offset_reg : cmd_line;
        fill_reg <= vga_fill_sel(cmd_fill, FILL_WORD);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      line_offset_reg <= '0;
    end else if (line_we) begin
      line_offset_reg <= line_wdata;
`ifdef VGA_BUF_SCROLL_EN
    end else if ((state_reg == S_DONE) && (op_reg == VGA_SCROLL)) begin
      line_offset_reg <= line_offset_reg + 1'b1;
`endif
    end
  end

  vga_fill_engine #(
    .H_CHARS (H_CHARS),
    .V_LINES (V_LINES)
  ) u_engine (
    .clock  (clock),
    .reset  (reset),
    .start  (accept),
    .active (eng_active),
    .stall  (cpu_we),
    .linear (op_reg == VGA_CLR_ALL),
    .line   (line_reg),
    .addr   (eng_addr),
    .last   (eng_last)
  );

  // CPU always wins the port; the engine simply waits out that cycle.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_we) begin
      mem_we    = 1'b1;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (eng_active) begin
      mem_we    = 1'b1;
      mem_addr  = eng_addr;
      mem_wdata = fill_reg;
    end
  end

  assign busy        = (state_reg != S_IDLE);
  assign cmd_ready   = ~busy;
  assign done        = (state_reg == S_DONE);
  assign line_offset = line_offset_reg;

endmodule

// File: tb/tb_vga_buf_ctrl.sv
// Scoreboard bench for vga_buf_ctrl: expected buffer writes are queued by the
// stimulus and consumed by a monitor that compares every mem_we cycle.
module tb_vga_buf_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_we = 1'b0;
  logic [11:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        line_we = 1'b0;
  logic [4:0]  line_wdata = '0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = '0;
  logic [4:0]  cmd_line = '0;
  logic [31:0] cmd_fill = '0;
  logic        cmd_ready, busy, done, mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [4:0]  line_offset;

  vga_buf_ctrl #(.H_CHARS(80)) dut (
    .clock(clock), .reset(reset),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .line_we(line_we), .line_wdata(line_wdata),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_line(cmd_line), .cmd_fill(cmd_fill),
    .cmd_ready(cmd_ready), .busy(busy), .done(done),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .line_offset(line_offset)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct packed {
    logic [11:0] a;
    logic [31:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   writes = 0;
  int   dones  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_line(input logic [4:0] ln, input logic [31:0] d, input int from, input int to);
    for (int h = from; h <= to; h++) exp_q.push_back('{a: {7'(h), ln}, d: d});
  endtask

  task automatic issue(input logic [1:0] op, input logic [4:0] ln, input logic [31:0] fill,
                       output int t_acc);
    chk("cmd_ready_before_issue", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_line  = ln;
    cmd_fill  = fill;
    t_acc     = cyc;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
  endtask

  task automatic wait_done(input int t_acc, input int w, input string name);
    int t_done;
    t_done = -1;
    for (int i = 0; i < w + 20; i++) begin
      if (done) begin
        t_done = cyc;
        break;
      end
      tick();
    end
    chk({name, "_done_cycle"}, t_done, t_acc + w + 1);
    tick();
    chk({name, "_ready_after"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    int t, w0, d0;
    exp_t e;

    fork
      forever begin
        @(negedge clock);
        if (mem_we) begin
          writes++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr %h data %h with empty queue", mem_addr, mem_wdata);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", {20'd0, mem_addr}, {20'd0, e.a});
            chk("wr_data", mem_wdata, e.d);
          end
        end
        if (done) dones++;
      end
    join_none

    // Reset state
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_done", {31'd0, done}, 32'd0);
    chk("idle_ready", {31'd0, cmd_ready}, 32'd1);
    chk("idle_line_offset", {27'd0, line_offset}, 32'd0);

    // 1: CPU pass-through
    exp_q.push_back('{a: 12'h0A5, d: 32'h12345678});
    cpu_we = 1'b1; cpu_addr = 12'h0A5; cpu_wdata = 32'h12345678;
    #1;
    chk("cpu_pass_we", {31'd0, mem_we}, 32'd1);
    chk("cpu_pass_addr", {20'd0, mem_addr}, 32'h0A5);
    chk("cpu_pass_data", mem_wdata, 32'h12345678);
    chk("cpu_pass_busy", {31'd0, busy}, 32'd0);
    tick();
    cpu_we = 1'b0;

    // 2: CLEAR_ALL with default fill
    for (int i = 0; i < 4096; i++) exp_q.push_back('{a: 12'(i), d: 32'hFFF00020});
    w0 = writes; d0 = dones;
    issue(2'd1, 5'd0, 32'd0, t);
    chk("clr_all_busy", {31'd0, busy}, 32'd1);
    wait_done(t, 4096, "clr_all");
    chk("clr_all_writes", writes - w0, 32'd4096);
    chk("clr_all_dones", dones - d0, 32'd1);

    // 3: CLEAR_LINE 5 with one CPU write after 40 engine writes
    push_line(5'd5, 32'h0F00F041, 0, 39);
    exp_q.push_back('{a: 12'h7FF, d: 32'hCAFEBABE});
    push_line(5'd5, 32'h0F00F041, 40, 79);
    w0 = writes;
    issue(2'd2, 5'd5, 32'h0F00F041, t);
    repeat (40) tick();
    cpu_we = 1'b1; cpu_addr = 12'h7FF; cpu_wdata = 32'hCAFEBABE;
    #1;
    chk("clr_line_cpu_addr", {20'd0, mem_addr}, 32'h7FF);
    tick();
    cpu_we = 1'b0;
    wait_done(t, 81, "clr_line");
    chk("clr_line_writes", writes - w0, 32'd81);

    // 4: SCROLL
    line_we = 1'b1; line_wdata = 5'd31;
    tick();
    line_we = 1'b0;
    chk("line_we_31", {27'd0, line_offset}, 32'd31);
`ifdef VGA_BUF_SCROLL_EN
    push_line(5'd31, 32'hABCD1234, 0, 79);
    issue(2'd3, 5'd2, 32'hABCD1234, t);
    wait_done(t, 80, "scroll_wrap");
    chk("scroll_wrap_offset", {27'd0, line_offset}, 32'd0);
    push_line(5'd0, 32'hFFF00020, 0, 79);
    issue(2'd3, 5'd9, 32'd0, t);
    repeat (80) tick();
    chk("scroll_done_now", {31'd0, done}, 32'd1);
    line_we = 1'b1; line_wdata = 5'd7;
    tick();
    line_we = 1'b0;
    chk("scroll_done_after", {31'd0, done}, 32'd0);
    chk("scroll_line_we_wins", {27'd0, line_offset}, 32'd7);
`else
    w0 = writes; d0 = dones;
    cmd_valid = 1'b1; cmd_op = 2'd3; cmd_line = 5'd2;
    tick();
    cmd_valid = 1'b0; cmd_op = 2'd0;
    chk("op3_not_busy", {31'd0, busy}, 32'd0);
    repeat (3) tick();
    chk("op3_offset_kept", {27'd0, line_offset}, 32'd31);
    chk("op3_no_writes", writes - w0, 32'd0);
    chk("op3_no_done", dones - d0, 32'd0);
    line_we = 1'b1; line_wdata = 5'd7;
    tick();
    line_we = 1'b0;
    chk("line_we_7", {27'd0, line_offset}, 32'd7);
`endif

    // 5: commands while busy are dropped
    push_line(5'd2, 32'h00000001, 0, 79);
    w0 = writes; d0 = dones;
    issue(2'd2, 5'd2, 32'h00000001, t);
    cmd_valid = 1'b1; cmd_op = 2'd1;
    repeat (5) tick();
    cmd_valid = 1'b0; cmd_op = 2'd0;
    wait_done(t, 80, "busy_drop");
    repeat (10) tick();
    chk("busy_drop_dones", dones - d0, 32'd1);
    chk("busy_drop_writes", writes - w0, 32'd80);
    chk("busy_drop_idle", {31'd0, busy}, 32'd0);

    // 6: reset during CLEAR_ALL when the pointer reaches 100
    line_we = 1'b1; line_wdata = 5'd9;
    tick();
    line_we = 1'b0;
    chk("line_we_9", {27'd0, line_offset}, 32'd9);
    for (int i = 0; i < 100; i++) exp_q.push_back('{a: 12'(i), d: 32'h11111111});
    w0 = writes; d0 = dones;
    issue(2'd1, 5'd0, 32'h11111111, t);
    repeat (100) tick();
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_mem_we", {31'd0, mem_we}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_line_offset", {27'd0, line_offset}, 32'd0);
    tick();
    chk("abort_mem_we_edge", {31'd0, mem_we}, 32'd0);
    reset = 1'b0;
    tick();
    chk("abort_queue_empty", exp_q.size(), 32'd0);
    chk("abort_writes", writes - w0, 32'd100);
    chk("abort_no_done", dones - d0, 32'd0);
    push_line(5'd3, 32'hFFF00020, 0, 79);
    issue(2'd2, 5'd3, 32'd0, t);
    wait_done(t, 80, "post_abort");

    repeat (3) tick();
    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
